// File: rtl/pip_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Optional performance counters are built when PIP_CTRL_PERF_CNT_EN is defined.
package pip_ctrl_pkg;

   // Execute operand source selected by the forwarding unit
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_W   = 2'b01,
      FWD_M   = 2'b10
   } fwd_sel_e;

   // Memory-stage access sequencer states
   typedef enum logic [1:0] {
      MEM_IDLE  = 2'b00,
      MEM_WAIT  = 2'b01,
      MEM_ERROR = 2'b10
   } mem_state_e;

   // ResultSrc encoding that marks a load in Execute
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pip_ctrl_fwd_unit.sv
// Forwarding select for one Execute operand: the Memory-stage ALU result has
// priority over the Writeback result; register x0 is never forwarded.
module pip_fwd_unit
   import pip_ctrl_pkg::*;
#(
   parameter int REGISTER_ADDRESS_WIDTH = 5
) (
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs_e_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m_i,
   input  logic                              reg_write_m_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w_i,
   input  logic                              reg_write_w_i,
   output logic [1:0]                        fwd_o
);

   // Pick the youngest in-flight producer of the Execute source register
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      fwd_o = FWD_REG;
      if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
         fwd_o = FWD_M;
      end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
         fwd_o = FWD_W;
      end
   end

endmodule

// File: rtl/pip_ctrl.sv
// Pipeline control: operand forwarding, load-use and branch hazards, and the
// Memory-stage wait/timeout sequencer. Memory stalls dominate every other
// hazard. Optional stall/flush counters are built when PIP_CTRL_PERF_CNT_EN
// is defined; otherwise StallCnt_o/FlushCnt_o read zero.
module pip_ctrl
   import pip_ctrl_pkg::*;
#(
   parameter int REGISTER_ADDRESS_WIDTH = 5,
   parameter int MEM_TIMEOUT            = 16,
   parameter int CNT_WIDTH              = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
   input  logic                              RegWriteM_i,
   input  logic                              RegWriteW_i,
   input  logic [1:0]                        ResultSrcE_i,
   input  logic                              PCSrcE_i,
   input  logic                              MemReqM_i,
   input  logic                              MemAckM_i,
   output logic [1:0]                        ForwardAE_o,
   output logic [1:0]                        ForwardBE_o,
   output logic                              StallF_o,
   output logic                              StallD_o,
   output logic                              StallE_o,
   output logic                              StallM_o,
   output logic                              FlushD_o,
   output logic                              FlushE_o,
   output logic                              FlushW_o,
   output logic                              MemErr_o,
   output logic [CNT_WIDTH-1:0]              StallCnt_o,
   output logic [CNT_WIDTH-1:0]              FlushCnt_o
);

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   mem_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_stall;
   logic              lw_stall;
   logic [1:0]        fwd_a, fwd_b;

   pip_fwd_unit #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_fwd_a (
      .rs_e_i        (Rs1E_i),
      .rd_m_i        (RdM_i),
      .reg_write_m_i (RegWriteM_i),
      .rd_w_i        (RdW_i),
      .reg_write_w_i (RegWriteW_i),
      .fwd_o         (fwd_a)
   );

   pip_fwd_unit #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_fwd_b (
      .rs_e_i        (Rs2E_i),
      .rd_m_i        (RdM_i),
      .reg_write_m_i (RegWriteM_i),
      .rd_w_i        (RdW_i),
      .reg_write_w_i (RegWriteW_i),
      .fwd_o         (fwd_b)
   );

   // A load in Execute whose destination is read by the instruction in Decode
   assign lw_stall = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                     ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

   // Memory sequencer next state; an ack always beats the timeout check
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_stall  = 1'b0;
      unique case (state_q)
         MEM_IDLE: begin
            if (MemReqM_i && !MemAckM_i) begin
               mem_stall  = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (MemAckM_i) begin
               state_d    = MEM_IDLE;
               wait_cnt_d = '0;
            end else begin
               mem_stall = 1'b1;
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d = MEM_ERROR;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
         end
         MEM_ERROR: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d    = MEM_IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Sequencer state register; the error state only leaves through reset
   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= MEM_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign MemErr_o = (state_q == MEM_ERROR);

   // Hazard resolution: reset forces bubbles, then memory stall, branch, load-use
   always_comb begin
      ForwardAE_o = FWD_REG;
      ForwardBE_o = FWD_REG;
      StallF_o    = 1'b0;
      StallD_o    = 1'b0;
      StallE_o    = 1'b0;
      StallM_o    = 1'b0;
      FlushD_o    = 1'b0;
      FlushE_o    = 1'b0;
      FlushW_o    = 1'b0;
      if (!rst_ni) begin
         FlushD_o = 1'b1;
         FlushE_o = 1'b1;
         FlushW_o = 1'b1;
      end else begin
         ForwardAE_o = fwd_a;
         ForwardBE_o = fwd_b;
         if (mem_stall) begin
            // Execute is frozen, so a pending branch is seen again after release
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
         end else if (PCSrcE_i) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
         end else if (lw_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
         end
      end
   end

`ifdef PIP_CTRL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters for fetch stalls and Execute bubbles
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallF_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (FlushE_o && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
   end

   // Counter registers; reset cycles are not counted
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt_o = stall_cnt_q;
   assign FlushCnt_o = flush_cnt_q;
`else
   assign StallCnt_o = '0;
   assign FlushCnt_o = '0;
`endif

endmodule
